fc_seq_classifier: RTL and testbench

FC_SEQ_CLASSIFIER -- requirements
Module: fc_seq_classifier

---
 rtl/fc_pkg.sv | 17 +
 rtl/fc_argmax.sv | 36 +++
 rtl/fc_seq_classifier.sv | 152 +++++++++++++++
 tb/tb_fc_seq_classifier.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and default sizing for the fully-connected classifier.
// Holds the sequencer state enum and default dimension constants.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BIAS,
        MAC,
        EMIT
    } fc_state_t;

    localparam int FC_IN_DIM  = 120;
    localparam int FC_OUT_DIM = 10;
    localparam int FC_DW      = 16;
    localparam int FC_FRAC    = 8;

endpackage

// File: rtl/fc_argmax.sv
// Running signed max/index tracker; ties keep the earlier (lower) index.
// Ports: clear (treat value as first), update, value, index -> best_val/best_idx.
module fc_argmax #(
    parameter int DW = 16,
    parameter int NW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 update,
    input  logic signed [DW-1:0] value,
    input  logic [NW-1:0]        index,
    output logic signed [DW-1:0] best_val,
    output logic [NW-1:0]        best_idx
);

    logic signed [DW-1:0] run_val;
    logic [NW-1:0]        run_idx;
    logic                 take;

    // Strict compare so an equal later value never displaces the holder.
    assign take     = clear || (value > run_val);
    assign best_val = take ? value : run_val;
    assign best_idx = take ? index : run_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_val <= '0;
            run_idx <= '0;
        end else if (update) begin
            run_val <= best_val;
            run_idx <= best_idx;
        end
    end

endmodule

// File: rtl/fc_seq_classifier.sv
// Sequential FC layer + argmax: streams bias/weights per neuron, one MAC per beat.
// Ports: x_we/x_addr/x_data load, start/busy, w_* stream, y_* results,
// done/classified/max_val. Define FC_RELU_EN to clamp negative outputs to 0.
module fc_seq_classifier
    import fc_pkg::*;
#(
    parameter int IN_DIM  = FC_IN_DIM,
    parameter int OUT_DIM = FC_OUT_DIM,
    parameter int DW      = FC_DW,
    parameter int FRAC    = FC_FRAC,
    localparam int AW     = (IN_DIM > 1) ? $clog2(IN_DIM) : 1,
    localparam int NW     = $clog2(OUT_DIM)
) (
    input  logic          clk,
    input  logic          RST_n,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_data,
    input  logic          start,
    output logic          busy,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [DW-1:0] w_data,
    output logic          y_valid,
    output logic [NW-1:0] y_idx,
    output logic [DW-1:0] y_data,
    output logic          done,
    output logic [NW-1:0] classified,
    output logic [DW-1:0] max_val
);

    localparam int ACCW = 2 * DW + $clog2(IN_DIM + 1);

    fc_state_t state, state_nx;

    logic signed [DW-1:0]   x_buf [IN_DIM];
    logic [AW-1:0]          i_cnt;
    logic [NW-1:0]          n_cnt;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] sh;
    logic signed [DW-1:0]   w_s;
    logic signed [2*DW-1:0] prod;
    logic signed [DW-1:0]   y_sat;
    logic signed [DW-1:0]   y_fin;
    logic signed [DW-1:0]   best_val;
    logic [NW-1:0]          best_idx;
    logic                   beat;
    logic                   last_i;
    logic                   last_n;

    assign w_s    = $signed(w_data);
    assign beat   = w_valid && w_ready;
    assign last_i = (32'(i_cnt) == IN_DIM - 1);
    assign last_n = (32'(n_cnt) == OUT_DIM - 1);
    assign prod   = x_buf[i_cnt] * w_s;

    assign busy    = (state != IDLE);
    assign w_ready = (state == BIAS) || (state == MAC);
    assign y_valid = (state == EMIT);
    assign y_idx   = n_cnt;
    assign y_data  = y_valid ? y_fin : '0;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = BIAS;
            BIAS: if (beat) state_nx = MAC;
            MAC:  if (beat && last_i) state_nx = EMIT;
            EMIT: state_nx = last_n ? IDLE : BIAS;
            default: state_nx = IDLE;
        endcase
    end

    // Input buffer survives reset so a vector can be reused across aborts.
    always_ff @(posedge clk) begin
        if (state == IDLE && x_we && 32'(x_addr) < IN_DIM)
            x_buf[x_addr] <= $signed(x_data);
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            i_cnt <= '0;
            n_cnt <= '0;
            acc   <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) n_cnt <= '0;
                BIAS: if (beat) begin
                    acc   <= ACCW'(w_s) <<< FRAC;
                    i_cnt <= '0;
                end
                MAC: if (beat) begin
                    acc   <= acc + ACCW'(prod);
                    i_cnt <= i_cnt + 1'b1;
                end
                EMIT: if (!last_n) n_cnt <= n_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Saturate when the bits above the DW-wide window disagree with its sign.
    assign sh = acc >>> FRAC;

    always_comb begin
        y_sat = sh[DW-1:0];
        if (!(&sh[ACCW-1:DW-1]) && (|sh[ACCW-1:DW-1]))
            y_sat = sh[ACCW-1] ? {1'b1, {(DW-1){1'b0}}}
                               : {1'b0, {(DW-1){1'b1}}};
    end

`ifdef FC_RELU_EN
    assign y_fin = y_sat[DW-1] ? '0 : y_sat;
`else
    assign y_fin = y_sat;
`endif

    fc_argmax #(
        .DW(DW),
        .NW(NW)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (RST_n),
        .clear   (n_cnt == '0),
        .update  (y_valid),
        .value   (y_fin),
        .index   (n_cnt),
        .best_val(best_val),
        .best_idx(best_idx)
    );

    // Results latch with done and hold until the next completion.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            done       <= 1'b0;
            classified <= '0;
            max_val    <= '0;
        end else begin
            done <= y_valid && last_n;
            if (y_valid && last_n) begin
                classified <= best_idx;
                max_val    <= best_val;
            end
        end
    end

endmodule

// File: tb/tb_fc_seq_classifier.sv
// Directed bench for fc_seq_classifier with IN_DIM=2, OUT_DIM=3, Q8.8 data.
// Expected values are hand-computed per scenario.
module tb_fc_seq_classifier;

    logic        clk = 0;
    logic        RST_n = 0;
    logic        x_we = 0;
    logic [0:0]  x_addr = 0;
    logic [15:0] x_data = 0;
    logic        start = 0;
    logic        busy;
    logic        w_valid = 0;
    logic        w_ready;
    logic [15:0] w_data = 0;
    logic        y_valid;
    logic [1:0]  y_idx;
    logic [15:0] y_data;
    logic        done;
    logic [1:0]  classified;
    logic [15:0] max_val;

    int total = 0;
    int bad = 0;

    logic [15:0] wv [9];
    logic [15:0] ycap [3];
    int ycnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int gaps = 0;

    always #5 clk = ~clk;

    fc_seq_classifier #(
        .IN_DIM (2),
        .OUT_DIM(3),
        .DW     (16),
        .FRAC   (8)
    ) dut (
        .clk       (clk),
        .RST_n     (RST_n),
        .x_we      (x_we),
        .x_addr    (x_addr),
        .x_data    (x_data),
        .start     (start),
        .busy      (busy),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .y_valid   (y_valid),
        .y_idx     (y_idx),
        .y_data    (y_data),
        .done      (done),
        .classified(classified),
        .max_val   (max_val)
    );

    always @(negedge clk) begin
        if (y_valid) begin
            if (y_idx < 3) ycap[y_idx] = y_data;
            ycnt++;
        end
        if (done) done_cnt++;
    end

    task automatic load_x(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        x_we = 1; x_addr = 0; x_data = a;
        @(negedge clk);
        x_addr = 1; x_data = b;
        @(negedge clk);
        x_we = 0;
    endtask

    task automatic set_w(input logic [15:0] a0, a1, a2,
                         input logic [15:0] b0, b1, b2,
                         input logic [15:0] c0, c1, c2);
        wv[0] = a0; wv[1] = a1; wv[2] = a2;
        wv[3] = b0; wv[4] = b1; wv[5] = b2;
        wv[6] = c0; wv[7] = c1; wv[8] = c2;
    endtask

    // Drives one inference; cyc = edges from start sample to done visible.
    task automatic run_inf(input bit gap_on, input bit inject);
        int idx;
        bit v;
        bit got;
        idx = 0; cyc = 0; gaps = 0; ycnt = 0; got = 0;
        for (int k = 0; k < 3; k++) ycap[k] = 16'hDEAD;
        @(negedge clk);
        start = 1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            start = 0; x_we = 0;
            if (done) begin
                got = 1;
                break;
            end
            cyc++;
            v = (idx < 9) && (!gap_on || $urandom_range(0, 2) != 0);
            w_valid = v;
            w_data = (idx < 9) ? wv[idx] : 16'h0;
            if (w_ready && v) idx++;
            else if (w_ready && !v) gaps++;
            if (inject && (n % 3 == 1)) begin
                start = 1; x_we = 1;
                x_addr = n[0]; x_data = 16'h7777;
            end
        end
        w_valid = 0; start = 0; x_we = 0;
        if (!got) begin
            total++; bad++;
            $display("FAIL timeout: done not seen, got %0d want 1", got);
        end
    endtask

    task automatic test_reset;
        RST_n = 0;
        repeat (3) @(negedge clk);
        total += 8;
        if (busy !== 0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        if (w_ready !== 0) begin bad++; $display("FAIL rst_wready got %b want 0", w_ready); end
        if (y_valid !== 0) begin bad++; $display("FAIL rst_yvalid got %b want 0", y_valid); end
        if (done !== 0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
        if (classified !== 0) begin bad++; $display("FAIL rst_cls got %0d want 0", classified); end
        if (max_val !== 0) begin bad++; $display("FAIL rst_max got %h want 0", max_val); end
        if (y_idx !== 0) begin bad++; $display("FAIL rst_yidx got %0d want 0", y_idx); end
        if (y_data !== 0) begin bad++; $display("FAIL rst_ydata got %h want 0", y_data); end
        RST_n = 1;
        @(negedge clk);
    endtask

    task automatic check_basic(input string tag);
        total += 6;
        if (ycnt !== 3) begin bad++; $display("FAIL %s ycnt got %0d want 3", tag, ycnt); end
        if (ycap[0] !== 16'h0300) begin bad++; $display("FAIL %s y0 got %h want 0300", tag, ycap[0]); end
        if (ycap[1] !== 16'h0380) begin bad++; $display("FAIL %s y1 got %h want 0380", tag, ycap[1]); end
        if (ycap[2] !== 16'h0000) begin bad++; $display("FAIL %s y2 got %h want 0000", tag, ycap[2]); end
        if (classified !== 1) begin bad++; $display("FAIL %s cls got %0d want 1", tag, classified); end
        if (max_val !== 16'h0380) begin bad++; $display("FAIL %s max got %h want 0380", tag, max_val); end
    endtask

    task automatic test_basic;
        load_x(16'h0100, 16'h0200);
        set_w(16'h0000, 16'h0100, 16'h0100,
              16'h0080, 16'hFF00, 16'h0200,
              16'h0000, 16'h0000, 16'h0000);
        run_inf(0, 0);
        check_basic("basic");
        total++;
        if (cyc !== 12) begin bad++; $display("FAIL basic_lat got %0d want 12", cyc); end
        @(negedge clk);
        total++;
        if (done !== 0) begin bad++; $display("FAIL done_pulse got %b want 0", done); end
        repeat (3) @(negedge clk);
        total++;
        if (classified !== 1 || max_val !== 16'h0380) begin
            bad++;
            $display("FAIL hold got %0d/%h want 1/0380", classified, max_val);
        end
    endtask

    task automatic test_gaps;
        run_inf(1, 0);
        check_basic("gaps");
        total++;
        if (cyc !== 12 + gaps) begin
            bad++;
            $display("FAIL gaps_lat got %0d want %0d", cyc, 12 + gaps);
        end
    endtask

    task automatic test_saturation;
        logic [15:0] e1;
`ifdef FC_RELU_EN
        e1 = 16'h0000;
`else
        e1 = 16'h8000;
`endif
        load_x(16'h7F00, 16'h7F00);
        set_w(16'h0000, 16'h7F00, 16'h7F00,
              16'h0000, 16'h8100, 16'h8100,
              16'h0100, 16'h0000, 16'h0000);
        run_inf(0, 0);
        total += 5;
        if (ycap[0] !== 16'h7FFF) begin bad++; $display("FAIL sat_pos got %h want 7fff", ycap[0]); end
        if (ycap[1] !== e1) begin bad++; $display("FAIL sat_neg got %h want %h", ycap[1], e1); end
        if (ycap[2] !== 16'h0100) begin bad++; $display("FAIL sat_y2 got %h want 0100", ycap[2]); end
        if (classified !== 0) begin bad++; $display("FAIL sat_cls got %0d want 0", classified); end
        if (max_val !== 16'h7FFF) begin bad++; $display("FAIL sat_max got %h want 7fff", max_val); end
    endtask

    task automatic test_ties;
        load_x(16'h0100, 16'h0000);
        set_w(16'h0100, 16'h0000, 16'h0000,
              16'h0100, 16'h0000, 16'h0000,
              16'h0100, 16'h0000, 16'h0000);
        run_inf(0, 0);
        total += 3;
        if (ycap[2] !== 16'h0100) begin bad++; $display("FAIL tie_y2 got %h want 0100", ycap[2]); end
        if (classified !== 0) begin bad++; $display("FAIL tie_cls got %0d want 0", classified); end
        if (max_val !== 16'h0100) begin bad++; $display("FAIL tie_max got %h want 0100", max_val); end
    endtask

    task automatic test_negative;
        logic [1:0]  ec;
        logic [15:0] em;
`ifdef FC_RELU_EN
        ec = 0; em = 16'h0000;
`else
        ec = 1; em = 16'hFF00;
`endif
        set_w(16'hFD00, 16'h0000, 16'h0000,
              16'hFF00, 16'h0000, 16'h0000,
              16'hFE00, 16'h0000, 16'h0000);
        run_inf(0, 0);
        total += 2;
        if (classified !== ec) begin bad++; $display("FAIL neg_cls got %0d want %0d", classified, ec); end
        if (max_val !== em) begin bad++; $display("FAIL neg_max got %h want %h", max_val, em); end
    endtask

    task automatic test_reset_mid;
        int idx;
        int dc;
        load_x(16'h0100, 16'h0200);
        set_w(16'h0000, 16'h0100, 16'h0100,
              16'h0080, 16'hFF00, 16'h0200,
              16'h0000, 16'h0000, 16'h0000);
        run_inf(0, 0);
        idx = 0;
        @(negedge clk);
        start = 1;
        for (int n = 0; n < 50 && idx < 5; n++) begin
            @(negedge clk);
            start = 0;
            w_valid = 1;
            w_data = wv[idx];
            if (w_ready) idx++;
        end
        @(negedge clk);
        w_valid = 0;
        dc = done_cnt;
        #2 RST_n = 0;
        #1;
        total += 5;
        if (busy !== 0) begin bad++; $display("FAIL mid_busy got %b want 0", busy); end
        if (w_ready !== 0) begin bad++; $display("FAIL mid_wready got %b want 0", w_ready); end
        if (y_idx !== 0) begin bad++; $display("FAIL mid_yidx got %0d want 0", y_idx); end
        if (classified !== 0) begin bad++; $display("FAIL mid_cls got %0d want 0", classified); end
        if (max_val !== 0) begin bad++; $display("FAIL mid_max got %h want 0", max_val); end
        repeat (2) @(negedge clk);
        RST_n = 1;
        repeat (20) @(negedge clk);
        total++;
        if (done_cnt !== dc) begin bad++; $display("FAIL mid_nodone got %0d want %0d", done_cnt, dc); end
        run_inf(0, 0);
        check_basic("restart");
    endtask

    task automatic test_busy_ignore;
        run_inf(0, 1);
        check_basic("inject");
        total++;
        if (cyc !== 12) begin bad++; $display("FAIL inject_lat got %0d want 12", cyc); end
        run_inf(0, 0);
        check_basic("after_inject");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_gaps;
        test_saturation;
        test_ties;
        test_negative;
        test_reset_mid;
        test_busy_ignore;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
